// File: rtl/sevenseg_capture_if.sv
// Multiplexed 7-segment scan bus (active-low anodes and cathodes).
// The display controller drives it as master; the capture monitor listens as slave.
interface sevenseg_capture_if;
  logic [7:0] an;
  logic [7:0] seg;

  modport master (output an, output seg);
  modport slave  (input an, input seg);
endinterface

// File: rtl/sevenseg_capture.sv
// Receiver for the 8-digit 7-segment scan bus: qualifies dwells, decodes digits, rebuilds frames.
// Optional frame counter output enabled by defining SEVSEG_FRAME_COUNT_EN.
module sevenseg_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  sevenseg_capture_if.slave       bus,
  output logic [4:0]              d0,
  output logic [4:0]              d1,
  output logic [4:0]              d2,
  output logic [4:0]              d3,
  output logic [4:0]              d4,
  output logic [4:0]              d5,
  output logic [4:0]              d6,
  output logic [4:0]              d7,
  output logic [7:0]              dp_out,
  output logic                    frame_valid,
  output logic                    seg_err,
  output logic                    an_err,
`ifdef SEVSEG_FRAME_COUNT_EN
  output logic [15:0]             frame_count,
`endif
  output logic                    seq_err
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [4:0] CodeBlank = 5'd23;
  localparam logic [4:0] CodeBad   = 5'd31;

  // Inverse of the display table; input is active-low g..a.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] c;
    case (p)
      7'h40: c = 5'd0;
      7'h79: c = 5'd1;
      7'h24: c = 5'd2;
      7'h30: c = 5'd3;
      7'h19: c = 5'd4;
      7'h12: c = 5'd5;
      7'h02: c = 5'd6;
      7'h78: c = 5'd7;
      7'h00: c = 5'd8;
      7'h10: c = 5'd9;
      7'h08: c = 5'd10;  // also 'R'; the lower code wins
      7'h03: c = 5'd11;
      7'h46: c = 5'd12;
      7'h21: c = 5'd13;
      7'h06: c = 5'd14;
      7'h0E: c = 5'd15;
      7'h7E: c = 5'd16;
      7'h7D: c = 5'd17;
      7'h7B: c = 5'd18;
      7'h77: c = 5'd19;
      7'h6F: c = 5'd20;
      7'h5F: c = 5'd21;
      7'h3F: c = 5'd22;
      7'h7F: c = CodeBlank;
      7'h09: c = 5'd24;
      7'h47: c = 5'd25;
      7'h4F: c = 5'd27;
      7'h2F: c = 5'd28;
      7'h11: c = 5'd29;
      default: c = CodeBad;
    endcase
    return c;
  endfunction

  logic [15:0]          s_q, s_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 captured_q, captured_d;
  logic [7:0][4:0]      dig_q, dig_d;
  logic [7:0]           dp_q, dp_d;
  logic [7:0]           mask_q, mask_d;
  logic [2:0]           last_idx_q, last_idx_d;
  logic                 last_vld_q, last_vld_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 seg_err_q, seg_err_d;
  logic                 an_err_q, an_err_d;
  logic                 seq_err_q, seq_err_d;

  logic       changed;
  logic       capture;
  logic [7:0] cap_an;
  logic [7:0] cap_seg;
  logic [7:0] low_bits;
  logic [2:0] idx;
  logic [4:0] code;
  logic [7:0] mask_new;

  always_comb begin
    s_d        = {bus.an, bus.seg};
    changed    = (s_d != s_q);
    cap_an     = s_q[15:8];
    cap_seg    = s_q[7:0];
    low_bits   = ~cap_an;
    capture    = (cnt_q == CntMax) && !captured_q;

    if (changed)               cnt_d = '0;
    else if (cnt_q == CntMax)  cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
    captured_d = changed ? 1'b0 : (captured_q | capture);

    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (low_bits[i]) idx = 3'(i);
    end
    code     = decode(cap_seg[6:0]);
    mask_new = mask_q;

    dig_d         = dig_q;
    dp_d          = dp_q;
    mask_d        = mask_q;
    last_idx_d    = last_idx_q;
    last_vld_d    = last_vld_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    an_err_d      = 1'b0;
    seq_err_d     = 1'b0;

    if (capture && (cap_an != 8'hFF)) begin
      if ((low_bits & (low_bits - 8'd1)) != 8'd0) begin
        an_err_d = 1'b1;
      end else begin
        dig_d[idx] = code;
        dp_d[idx]  = ~cap_seg[7];
        seg_err_d  = (code == CodeBad);
        // A break in scan order restarts frame assembly at this digit.
        if (last_vld_q && (idx != last_idx_q + 3'd1)) begin
          seq_err_d = 1'b1;
          mask_new  = 8'd1 << idx;
        end else begin
          mask_new  = mask_q | (8'd1 << idx);
        end
        last_idx_d = idx;
        last_vld_d = 1'b1;
        if (mask_new == 8'hFF) begin
          frame_valid_d = 1'b1;
          mask_d        = 8'h00;
        end else begin
          mask_d        = mask_new;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q           <= 16'hFFFF;
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      dig_q         <= {8{CodeBlank}};
      dp_q          <= 8'h00;
      mask_q        <= 8'h00;
      last_idx_q    <= 3'd0;
      last_vld_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      an_err_q      <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      s_q           <= s_d;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      dig_q         <= dig_d;
      dp_q          <= dp_d;
      mask_q        <= mask_d;
      last_idx_q    <= last_idx_d;
      last_vld_q    <= last_vld_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      an_err_q      <= an_err_d;
      seq_err_q     <= seq_err_d;
    end
  end

`ifdef SEVSEG_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_valid_d) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) fcnt_q <= 16'd0;
    else        fcnt_q <= fcnt_d;
  end

  assign frame_count = fcnt_q;
`endif

  assign d0          = dig_q[0];
  assign d1          = dig_q[1];
  assign d2          = dig_q[2];
  assign d3          = dig_q[3];
  assign d4          = dig_q[4];
  assign d5          = dig_q[5];
  assign d6          = dig_q[6];
  assign d7          = dig_q[7];
  assign dp_out      = dp_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign an_err      = an_err_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Randomized self-checking bench for sevenseg_capture against a dwell/frame reference model.
module tb_sevenseg_capture;
  localparam int unsigned Settle = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] dp_out;
  logic frame_valid, seg_err, an_err, seq_err;
`ifdef SEVSEG_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  sevenseg_capture_if bus ();

  sevenseg_capture #(
    .SETTLE_CYCLES (Settle),
    .CNT_WIDTH     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .d6          (d6),
    .d7          (d7),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
`ifdef SEVSEG_FRAME_COUNT_EN
    .frame_count (frame_count),
`endif
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          fire;
    logic [15:0] v;
  } cap_t;

  int errors = 0;
  int checks = 0;

  // Active-high gfedcba glyph for each code; codes 26, 30, 31 have none.
  logic [6:0] glyph [32];
  bit         glyph_ok [32];

  logic [4:0]  m_dig [8];
  logic [7:0]  m_dp;
  bit          m_seen [8];
  int          m_last;
  logic [15:0] m_fcnt;
  cap_t        pend [$];
  logic [15:0] last_v;
  int          held;
  int          cyc = 0;
  int          n_fv = 0, n_seg = 0, n_an = 0, n_seq = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] low);
    logic [6:0] lit;
    lit = ~low;
    for (int c = 0; c < 32; c++) begin
      if (glyph_ok[c] && glyph[c] == lit) return 5'(c);
    end
    return 5'd31;
  endfunction

  function automatic logic [7:0] seg_of(input int code, input bit dp_on);
    logic [6:0] g;
    g = glyph[code];
    return {~dp_on, ~g};
  endfunction

  function automatic logic [7:0] an_of(input int pos);
    logic [7:0] one;
    one = 8'd1 << pos;
    return ~one;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_dig[i]  = 5'd23;
      m_seen[i] = 1'b0;
    end
    m_dp   = 8'h00;
    m_last = -1;
    m_fcnt = 16'd0;
  endtask

  // Applies one qualified dwell value; returns {frame_valid, seg_err, an_err, seq_err}.
  task automatic model_capture(input logic [15:0] v, output logic [3:0] p);
    logic [7:0] an;
    int         idx;
    bit         full;
    p  = 4'b0000;
    an = v[15:8];
    if (an == 8'hFF) return;
    if ($countones(~an) > 1) begin
      p[1] = 1'b1;
      return;
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
    m_dig[idx] = ref_decode(v[6:0]);
    m_dp[idx]  = ~v[7];
    if (m_dig[idx] == 5'd31) p[2] = 1'b1;
    if (m_last >= 0 && idx != (m_last + 1) % 8) begin
      p[0] = 1'b1;
      for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
    end
    m_seen[idx] = 1'b1;
    m_last = idx;
    full = 1'b1;
    for (int i = 0; i < 8; i++) if (!m_seen[i]) full = 1'b0;
    if (full) begin
      p[3] = 1'b1;
      for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
      m_fcnt = m_fcnt + 16'd1;
    end
  endtask

  task automatic compare_outputs(input logic [3:0] exp_p);
    logic [39:0] exp_d;
    for (int i = 0; i < 8; i++) exp_d[i*5 +: 5] = m_dig[i];
    check("pulses", 64'({frame_valid, seg_err, an_err, seq_err}), 64'(exp_p));
    check("digits", 64'({d7, d6, d5, d4, d3, d2, d1, d0}), 64'(exp_d));
    check("dp_out", 64'(dp_out), 64'(m_dp));
`ifdef SEVSEG_FRAME_COUNT_EN
    check("frame_count", 64'(frame_count), 64'(m_fcnt));
`endif
  endtask

  task automatic step();
    logic [3:0] exp_p;
    cap_t       c;
    @(posedge clk);
    #1;
    cyc++;
    held++;
    exp_p = 4'b0000;
    if (pend.size() > 0 && pend[0].fire == cyc) begin
      c = pend.pop_front();
      model_capture(c.v, exp_p);
    end
    if (frame_valid) n_fv++;
    if (seg_err)     n_seg++;
    if (an_err)      n_an++;
    if (seq_err)     n_seq++;
    compare_outputs(exp_p);
  endtask

  task automatic apply(input logic [7:0] an, input logic [7:0] seg, input int n);
    logic [15:0] v;
    v = {an, seg};
    if (v != last_v) begin
      // A dwell shorter than the settle window never qualifies.
      if (held < int'(Settle) && pend.size() > 0) void'(pend.pop_back());
      pend.push_back('{fire: cyc + 1 + int'(Settle), v: v});
      last_v = v;
      held   = 0;
    end
    bus.an  = an;
    bus.seg = seg;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    pend.delete();
    model_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.an  = 8'($urandom);
      bus.seg = 8'($urandom);
      @(posedge clk);
      #1;
      cyc++;
      compare_outputs(4'b0000);
    end
    reset   = 1'b1;
    last_v  = 16'hFFFF;
    held    = 1000;
    apply(8'hFF, 8'hFF, 3);
  endtask

  task automatic digit(input int pos, input int code, input bit dp_on, input int n);
    apply(an_of(pos), seg_of(code, dp_on), n);
  endtask

  initial begin
    int fv0, seq0, seg0, an0;
    int pos, code, dwell, r;
    logic [7:0] an_r, seg_r;
    logic [39:0] exp_d;

    for (int c = 0; c < 32; c++) begin
      glyph[c]    = 7'h00;
      glyph_ok[c] = 1'b0;
    end
    glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
    glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    for (int s = 0; s < 7; s++) glyph[16 + s] = 7'd1 << s;
    glyph[23] = 7'h00; glyph[24] = 7'h76; glyph[25] = 7'h38;
    glyph[27] = 7'h30; glyph[28] = 7'h50; glyph[29] = 7'h6E;
    for (int c = 0; c < 30; c++) glyph_ok[c] = (c != 26);

    bus.an  = 8'hFF;
    bus.seg = 8'hFF;
    reset   = 1'b0;
    model_reset();

    // Reset state.
    do_reset();
    check("reset_digits", 64'({d7, d6, d5, d4, d3, d2, d1, d0}), 64'({8{5'd23}}));
    check("reset_dp", 64'(dp_out), 64'h00);

    // Ordered frame 1..8, dp at position 3.
    fv0 = n_fv;
    for (int i = 0; i < 8; i++) digit(i, i + 1, (i == 3), 10);
    apply(8'hFF, 8'hFF, 6);
    check("frame_digits", 64'({d7, d6, d5, d4, d3, d2, d1, d0}),
          64'({5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
    check("frame_dp", 64'(dp_out), 64'h08);
    check("frame_once", 64'(n_fv - fv0), 64'd1);

    // Glitch shorter than the settle window is ignored.
    digit(0, 5, 1'b0, 10);
    digit(0, 9, 1'b0, 3);
    digit(0, 5, 1'b0, 10);
    check("glitch_d0", 64'(d0), 64'd5);

    // Out-of-order capture restarts the frame.
    do_reset();
    fv0 = n_fv; seq0 = n_seq;
    digit(0, 3, 1'b0, 8);
    digit(2, 4, 1'b0, 8);
    apply(8'hFF, 8'hFF, 6);
    check("order_seq", 64'(n_seq - seq0), 64'd1);
    check("order_nofv", 64'(n_fv - fv0), 64'd0);
    for (int i = 3; i < 10; i++) digit(i % 8, i, 1'b0, 8);
    apply(8'hFF, 8'hFF, 6);
    check("order_fv", 64'(n_fv - fv0), 64'd1);

    // Undecodable pattern, multiple anodes, shared A/R glyph.
    seg0 = n_seg; an0 = n_an;
    apply(an_of(1), {1'b1, 7'b1010101}, 8);
    apply(8'hFF, 8'hFF, 6);
    check("bad_seg_d1", 64'(d1), 64'd31);
    check("bad_seg_pulse", 64'(n_seg - seg0), 64'd1);
    exp_d = {d7, d6, d5, d4, d3, d2, d1, d0};
    apply(8'b11110011, 8'h40, 8);
    apply(8'hFF, 8'hFF, 6);
    check("an_err_pulse", 64'(n_an - an0), 64'd1);
    check("an_err_nodata", 64'({d7, d6, d5, d4, d3, d2, d1, d0}), 64'(exp_d));
    apply(an_of(2), {1'b1, 7'b0001000}, 8);
    apply(8'hFF, 8'hFF, 6);
    check("shared_a_r", 64'(d2), 64'd10);

    // Reset mid-frame discards partial progress.
    do_reset();
    fv0 = n_fv;
    for (int i = 0; i < 4; i++) digit(i, i, 1'b0, 8);
    apply(8'hFF, 8'hFF, 6);
    do_reset();
    for (int i = 4; i < 8; i++) digit(i, i, 1'b0, 8);
    apply(8'hFF, 8'hFF, 6);
    check("midreset_nofv", 64'(n_fv - fv0), 64'd0);
    for (int i = 0; i < 4; i++) digit(i, i, 1'b0, 8);
    apply(8'hFF, 8'hFF, 6);
    check("midreset_fv1", 64'(n_fv - fv0), 64'd1);
    for (int i = 0; i < 8; i++) digit(i, 15 - i, 1'b1, 8);
    apply(8'hFF, 8'hFF, 6);
    check("midreset_fv2", 64'(n_fv - fv0), 64'd2);
`ifdef SEVSEG_FRAME_COUNT_EN
    check("frame_count_2", 64'(frame_count), 64'd2);
`endif

    // Randomized scans: mostly in order, with blanks, glitches, bad anodes and bad glyphs.
    pos = 0;
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        an_r = 8'hFF;
      end else if (r < 13) begin
        an_r = 8'($urandom) & an_of(int'($urandom_range(0, 7)));
        an_r[int'($urandom_range(0, 7))] = 1'b0;
        if ($countones(~an_r) < 2) an_r = 8'b0111_1110;
      end else begin
        if (r < 25) pos = int'($urandom_range(0, 7));
        an_r = an_of(pos);
        pos  = (pos + 1) % 8;
      end
      if ($urandom_range(0, 9) < 8) begin
        code = int'($urandom_range(0, 29));
        if (code == 26) code = 24;
        seg_r = seg_of(code, 1'($urandom));
      end else begin
        seg_r = 8'($urandom);
      end
      dwell = int'($urandom_range(1, 8));
      apply(an_r, seg_r, dwell);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    apply(8'hFF, 8'hFF, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
Monitor/receiver for the multiplexed 8-digit 7-segment bus (an/seg) produced by the display controller. It samples the active-low anode and cathode lines, qualifies each digit dwell for stability, and decodes the cathode pattern back to the 5-bit digit code and decimal point. It rebuilds full 8-digit frames for loopback self-test and verification, and flags malformed or out-of-order scans.

Parameters:
SETTLE_CYCLES, 4, cycles {an,seg} must be unchanged before a capture (minimum 1)
CNT_WIDTH, 8, width of the stability counter (must hold SETTLE_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-low
an  input  8  anode lines, active-low, one-hot-low when a digit is lit
seg  input  8  cathodes, active-low; seg[7]=dp, seg[6:0]=g..a
d0..d7  output  5 each  decoded digit codes, one per anode position (an[i] maps to di)
dp_out  output  8  decoded decimal points, 1=on
frame_valid  output  1  one-cycle pulse: all 8 digits captured in scan order
seg_err  output  1  one-cycle pulse: captured pattern matches no code
an_err  output  1  one-cycle pulse: stable anode with more than one bit low
seq_err  output  1  one-cycle pulse: digit captured out of scan order

Behaviour:
- Reset (reset==0 at clk edge): d0..d7=23 (blank), dp_out=0, all pulses 0, seen mask=0, last_idx invalid, stability counter=0, captured flag=0.
- Input stage: {an,seg} registered into s each clock. E0 is the first edge at which s holds a new value.
- Stability: cnt=0 when s changes, else increments, saturating at SETTLE_CYCLES-1. captured flag clears on any change.
- Capture fires when cnt==SETTLE_CYCLES-1 and captured==0. It then sets captured, so there is at most one capture per dwell. Outputs update at edge E0+SETTLE_CYCLES.
- A glitch shorter than SETTLE_CYCLES produces no capture.
- Capture with an==8'hFF: no action (idle/blank scan).
- Capture with more than one an bit low: an_err pulse. No data update, and mask/order are unchanged.
- Valid capture with idx = position of the low an bit:
  - di = decode(seg[6:0]).
  - dp_out[idx] = ~seg[7].
- Decode is the inverse of the display table:
  - 0-9 and A-F map to 0-15.
  - Single segments a-g map to 16-22.
  - Blank 7'h7F maps to 23.
  - H=24, L=25, l=27, r=28, y=29.
  - Pattern 7'b0001000 (shared by A and R) decodes to 10; the lowest code wins.
  - Any other pattern: di=31 and seg_err pulse (data still stored).
- Order check: expected idx = (last_idx+1) mod 8.
  - If last_idx is valid and idx != expected: seq_err pulse, and mask = only bit idx.
  - Otherwise mask |= bit idx.
  - In both cases last_idx = idx.
- Frame completion: when the updated mask would be 8'hFF, frame_valid pulses on the same edge as the completing digit's data, and mask clears to 0. The next frame can start at any index consistent with the order check.
- Simultaneous seg_err and frame completion: both pulse.
- Reset mid-frame: mask and last_idx discarded immediately. Partial data is not retained; outputs return to reset values.

Optional Feature:
- Macro SEVSEG_FRAME_COUNT_EN.
- When defined: adds output frame_count (16 bits), reset 0, incremented on every frame_valid, wraps 16'hFFFF to 0.
- When undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 clocks with random an/seg -> d0..d7=23, dp_out=8'h00, all pulses 0.
- Ordered frame: an scans 8'hFE..8'h7F, each position shows digits 1..8 with dp on at position 3 only, dwell 10 cycles (SETTLE_CYCLES=4) -> d0..d7=1..8, dp_out=8'h08, exactly one frame_valid on the position-7 capture edge, latency 4 edges from E0.
- Glitch: hold position 0 with pattern "5", then a 3-cycle blip of "9", then "5" again -> d0 stays 5 and no extra capture.
- Order error: capture position 0, then position 2 -> seq_err pulse, no frame_valid. Then positions 3..7,0,1 -> frame_valid once.
- Bad inputs: seg[6:0]=7'b1010101 -> di=31 and seg_err pulse; an=8'b11110011 stable -> an_err pulse, no di change. Pattern 7'b0001000 -> di=10.
- Reset mid-frame: after 4 digits, pulse reset, then capture positions 4..7 -> no frame_valid until a full 8 digits. With SEVSEG_FRAME_COUNT_EN, frame_count counts 0->1->2 over two good frames.
